// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard unit and the decoder: Tnew/Tuse timing, MDU op codes, timer states.
// The optional performance counters in the top level are enabled with the HAZ_PERF_EN macro.
package hazard_pkg;

   // Tnew/Tuse: cycles until a value is produced/consumed; Tuse == 3 means "source not read"
   typedef logic [1:0] t_tcyc;
   localparam t_tcyc TUSE_NONE = 2'd3;

   typedef enum logic [1:0] {
      MD_NONE = 2'd0,
      MD_MULT = 2'd1,
      MD_DIV  = 2'd2,
      MD_RSVD = 2'd3
   } md_op_e;

   localparam int MULT_CYC_DEF = 5;
   localparam int DIV_CYC_DEF  = 10;
   localparam int CNT_W        = 4;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } timer_state_e;

   // A source stalls when a producer in E or M will not have its result ready in time.
   function automatic logic src_hazard(input logic [4:0] src,
                                       input t_tcyc      tuse,
                                       input logic [4:0] waddr_e,
                                       input t_tcyc      tnew_e,
                                       input logic [4:0] waddr_m,
                                       input t_tcyc      tnew_m);
      return (src != 5'd0) && (tuse != TUSE_NONE) &&
             (((src == waddr_e) && (tuse < tnew_e)) ||
              ((src == waddr_m) && (tuse < tnew_m)));
   endfunction

   function automatic logic is_md_op(input logic [1:0] op);
      return (op == MD_MULT) || (op == MD_DIV);
   endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// D/E/M-stage hazard inputs and stall outputs between the pipeline datapath and the hazard unit.
interface hazard_stall_ctrl_if;
   logic [4:0] rs_D;
   logic [4:0] rt_D;
   logic [1:0] tuse_rs_D;
   logic [1:0] tuse_rt_D;
   logic       md_use_D;
   logic [4:0] waddr_E;
   logic [1:0] tnew_E;
   logic [4:0] waddr_M;
   logic [1:0] tnew_M;
   logic [1:0] md_op_E;
   logic       en_PC;
   logic       en_D;
   logic       flush_E;
   logic       md_busy;

   modport master (
      output rs_D, rt_D, tuse_rs_D, tuse_rt_D, md_use_D,
             waddr_E, tnew_E, waddr_M, tnew_M, md_op_E,
      input  en_PC, en_D, flush_E, md_busy
   );

   modport slave (
      input  rs_D, rt_D, tuse_rs_D, tuse_rt_D, md_use_D,
             waddr_E, tnew_E, waddr_M, tnew_M, md_op_E,
      output en_PC, en_D, flush_E, md_busy
   );
endinterface

// File: rtl/md_busy_timer.sv
// MDU occupancy timer: loads the op latency as a mult/div leaves E, then counts down to idle.
module md_busy_timer
   import hazard_pkg::*;
#(
   parameter int MULT_CYC = MULT_CYC_DEF,
   parameter int DIV_CYC  = DIV_CYC_DEF    // must fit the 4-bit counter (<= 15)
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] md_op,
   output logic       busy
);

   timer_state_e     r_state;
   timer_state_e     w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // A new op always reloads, even while running; decoding normally keeps that from happening.
   always_comb begin
      // NOTE: defaults first so no path through the block leaves a variable unassigned (no latch).
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      if (md_op == MD_MULT) begin
         w_cnt_nxt   = CNT_W'(MULT_CYC);
         w_state_nxt = ST_RUN;
      end else if (md_op == MD_DIV) begin
         w_cnt_nxt   = CNT_W'(DIV_CYC);
         w_state_nxt = ST_RUN;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (r_cnt != '0) w_cnt_nxt = r_cnt - 1'b1;
               if (r_cnt <= CNT_W'(1)) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   assign busy = (r_cnt != '0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/bubble scheduler: Tuse-vs-Tnew comparators, MDU stall and the stall OR-tree.
// Define HAZ_PERF_EN to add the stall_cnt / md_stall_cnt performance counters.
module hazard_stall_ctrl
   import hazard_pkg::*;
#(
   parameter int MULT_CYC = MULT_CYC_DEF,
   parameter int DIV_CYC  = DIV_CYC_DEF
) (
   input  logic                clk,
   input  logic                reset,
   hazard_stall_ctrl_if.slave  hif
`ifdef HAZ_PERF_EN
   ,
   output logic [31:0]         stall_cnt,
   output logic [31:0]         md_stall_cnt
`endif
);

   logic w_stall_rs;
   logic w_stall_rt;
   logic w_md_stall;
   logic w_stall;
   logic w_md_busy;

   md_busy_timer #(
      .MULT_CYC (MULT_CYC),
      .DIV_CYC  (DIV_CYC)
   ) u_timer (
      .clk   (clk),
      .reset (reset),
      .md_op (hif.md_op_E),
      .busy  (w_md_busy)
   );

   assign w_stall_rs = src_hazard(hif.rs_D, hif.tuse_rs_D, hif.waddr_E, hif.tnew_E,
                                  hif.waddr_M, hif.tnew_M);
   assign w_stall_rt = src_hazard(hif.rt_D, hif.tuse_rt_D, hif.waddr_E, hif.tnew_E,
                                  hif.waddr_M, hif.tnew_M);

   // While reset is held the MDU is considered empty, so only data hazards may stall.
   assign w_md_stall = reset && hif.md_use_D && (w_md_busy || is_md_op(hif.md_op_E));
   assign w_stall    = w_stall_rs | w_stall_rt | w_md_stall;

   assign hif.en_PC   = !w_stall;
   assign hif.en_D    = !w_stall;
   assign hif.flush_E = w_stall;
   assign hif.md_busy = w_md_busy;

`ifdef HAZ_PERF_EN
   logic [31:0] r_stall_cnt;
   logic [31:0] r_md_stall_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stall_cnt    <= '0;
         r_md_stall_cnt <= '0;
      end else begin
         r_stall_cnt    <= r_stall_cnt + 32'(w_stall);
         r_md_stall_cnt <= r_md_stall_cnt + 32'(w_md_stall);
      end
   end

   assign stall_cnt    = r_stall_cnt;
   assign md_stall_cnt = r_md_stall_cnt;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: directed vectors push expectations, a negedge monitor checks.
module tb_hazard_stall_ctrl;

   typedef struct {
      string       name;
      logic [3:0]  outs;   // {en_PC, en_D, flush_E, md_busy}
      logic [31:0] sc;
      logic [31:0] msc;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   hazard_stall_ctrl_if hif ();

`ifdef HAZ_PERF_EN
   logic [31:0] stall_cnt;
   logic [31:0] md_stall_cnt;
`endif

   hazard_stall_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .hif          (hif)
`ifdef HAZ_PERF_EN
      ,
      .stall_cnt    (stall_cnt),
      .md_stall_cnt (md_stall_cnt)
`endif
   );

   exp_t        sb_q[$];
   exp_t        mon_e;
   int          n_cmp  = 0;
   int          n_fail = 0;
   logic [31:0] m_sc   = '0;
   logic [31:0] m_msc  = '0;
   bit          pend_stall = 1'b0;
   bit          pend_md    = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [4:0] rs, input logic [1:0] tuse_rs,
                        input logic [4:0] rt, input logic [1:0] tuse_rt,
                        input logic [4:0] we, input logic [1:0] tne,
                        input logic [4:0] wm, input logic [1:0] tnm,
                        input logic [1:0] op, input logic use_md);
      hif.rs_D      = rs;
      hif.tuse_rs_D = tuse_rs;
      hif.rt_D      = rt;
      hif.tuse_rt_D = tuse_rt;
      hif.waddr_E   = we;
      hif.tnew_E    = tne;
      hif.waddr_M   = wm;
      hif.tnew_M    = tnm;
      hif.md_op_E   = op;
      hif.md_use_D  = use_md;
   endtask

   // Advance one cycle; the perf model counts the previous cycle only if reset was released at the edge.
   task automatic next_cycle();
      @(posedge clk);
      if (reset) begin
         m_sc  = m_sc + 32'(pend_stall);
         m_msc = m_msc + 32'(pend_md);
      end
      pend_stall = 1'b0;
      pend_md    = 1'b0;
      #1;
   endtask

   task automatic expect_now(input string name, input bit stall, input bit md_stall, input bit busy);
      exp_t e;
      e.name = name;
      e.outs = {!stall, !stall, stall, busy};
      e.sc   = m_sc;
      e.msc  = m_msc;
      sb_q.push_back(e);
      pend_stall = stall;
      pend_md    = md_stall;
   endtask

   always @(negedge clk) begin
      if (sb_q.size() != 0) begin
         mon_e = sb_q.pop_front();
         check({mon_e.name, " outs"}, 32'({hif.en_PC, hif.en_D, hif.flush_E, hif.md_busy}), 32'(mon_e.outs));
`ifdef HAZ_PERF_EN
         check({mon_e.name, " stall_cnt"}, stall_cnt, mon_e.sc);
         check({mon_e.name, " md_stall_cnt"}, md_stall_cnt, mon_e.msc);
`endif
      end
   end

   initial begin
      reset = 1'b0;
      drive(0, 3, 0, 3, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #3 reset = 1'b1;

      // Reset state, then mult timing: issue cycle + 5 busy cycles stall, 7th releases
      next_cycle(); drive(0, 3, 0, 3, 0, 0, 0, 0, 0, 0); expect_now("idle", 0, 0, 0);
      next_cycle(); drive(0, 3, 0, 3, 0, 0, 0, 0, 1, 1); expect_now("mult_issue", 1, 1, 0);
      for (int i = 1; i <= 5; i++) begin
         next_cycle(); drive(0, 3, 0, 3, 0, 0, 0, 0, 0, 1);
         expect_now($sformatf("mult_busy%0d", i), 1, 1, 1);
      end
      next_cycle(); drive(0, 3, 0, 3, 0, 0, 0, 0, 0, 1); expect_now("mult_release", 0, 0, 0);

      // Load-use through E then M, and rt-side Tuse/Tnew boundary
      next_cycle(); drive(8, 0, 0, 3, 8, 2, 0, 0, 0, 0); expect_now("lu_E", 1, 0, 0);
      next_cycle(); drive(8, 0, 0, 3, 0, 0, 8, 1, 0, 0); expect_now("lu_M", 1, 0, 0);
      next_cycle(); drive(8, 0, 0, 3, 0, 0, 8, 0, 0, 0); expect_now("lu_clear", 0, 0, 0);
      next_cycle(); drive(0, 3, 8, 1, 8, 2, 0, 0, 0, 0); expect_now("rt_stall", 1, 0, 0);
      next_cycle(); drive(0, 3, 8, 2, 8, 2, 0, 0, 0, 0); expect_now("rt_equal", 0, 0, 0);

      // No false stall: r0 and unused sources
      next_cycle(); drive(0, 0, 0, 3, 0, 2, 0, 0, 0, 0); expect_now("r0_guard", 0, 0, 0);
      next_cycle(); drive(0, 3, 9, 3, 9, 2, 0, 0, 0, 0); expect_now("rt_unused", 0, 0, 0);

      // Reserved MDU op is treated as none
      next_cycle(); drive(0, 3, 0, 3, 0, 0, 0, 0, 3, 1); expect_now("md_rsvd", 0, 0, 0);
      next_cycle(); drive(0, 3, 0, 3, 0, 0, 0, 0, 0, 1); expect_now("md_rsvd_after", 0, 0, 0);

      // Div then mflo: 10 busy cycles, cnt==1 still stalls, release shows en_D=1
      next_cycle(); drive(0, 3, 0, 3, 0, 0, 0, 0, 2, 0); expect_now("div_issue", 0, 0, 0);
      for (int i = 1; i <= 10; i++) begin
         next_cycle(); drive(0, 3, 0, 3, 0, 0, 0, 0, 0, 1);
         expect_now($sformatf("div_busy%0d", i), 1, 1, 1);
      end
      next_cycle(); drive(0, 3, 0, 3, 0, 0, 0, 0, 0, 1); expect_now("div_release", 0, 0, 0);

      // Reset mid-div at cnt==6, asserted between edges
      next_cycle(); drive(0, 3, 0, 3, 0, 0, 0, 0, 2, 0); expect_now("div2_issue", 0, 0, 0);
      for (int i = 1; i <= 4; i++) begin
         next_cycle(); drive(0, 3, 0, 3, 0, 0, 0, 0, 0, 0);
         expect_now($sformatf("div2_busy%0d", i), 0, 0, 1);
      end
      next_cycle(); drive(0, 3, 0, 3, 0, 0, 0, 0, 0, 1);
      #2 reset = 1'b0;
      m_sc  = '0;
      m_msc = '0;
      expect_now("rst_async", 0, 0, 0);
      next_cycle(); drive(8, 0, 0, 3, 8, 2, 0, 0, 1, 1); expect_now("rst_hold_data", 1, 0, 0);
      next_cycle(); drive(0, 3, 0, 3, 0, 0, 0, 0, 0, 1);
      #2 reset = 1'b1;
      expect_now("rst_release", 0, 0, 0);
      next_cycle(); drive(0, 3, 0, 3, 0, 0, 0, 0, 0, 1); expect_now("post_rst", 0, 0, 0);
      next_cycle(); drive(0, 3, 0, 3, 0, 0, 0, 0, 1, 1); expect_now("post_rst_mult", 1, 1, 0);
      next_cycle(); drive(0, 3, 0, 3, 0, 0, 0, 0, 0, 1); expect_now("post_rst_busy", 1, 1, 1);

      for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
      if (sb_q.size() != 0) check("drain", 32'(sb_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
